// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
// The optional RUN timeout is enabled by defining MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

  localparam int WORD_W             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Requester index width, kept at least one bit so a single requester still has an id.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: request handshake plus result return.
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_a;
  logic [NUM_REQ*WORD_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [WORD_W-1:0]         resp_data;
  logic                      resp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr (wrapping) wins.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative 32x32 multiplier among NUM_REQ requesters with round-robin arbitration.
// Defining MULT_ARB_TIMEOUT_EN adds a RUN-cycle watchdog that aborts a stuck multiplication.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  mult_arbiter_if.slave     bus,
  output logic              busy,
  output logic [WORD_W-1:0] mul_a,
  output logic [WORD_W-1:0] mul_b,
  output logic              mul_start,
  output logic              mul_reset,
  input  logic [WORD_W-1:0] mul_out,
  input  logic              mul_done
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t state, state_next;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic               accept;
  logic               finish;
  logic               abort;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic [WORD_W-1:0]  resp_data_q;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt;
  logic             abort_q;
  logic             resp_err_q;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // The accept pulse is the only combinational output, so it is gated by reset as well.
  assign bus.req_ready  = win_grant & {NUM_REQ{accept}};
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (win_any && !reset) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = RUN;
      RUN: begin
        if (mul_done) begin
          finish     = 1'b1;
          state_next = RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          finish     = 1'b1;
          abort      = 1'b1;
          state_next = RESP;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= ID_W'(NUM_REQ - 1);
      owner        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      busy         <= 1'b0;
      mul_start    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      busy         <= (state_next != IDLE);
      mul_start    <= (state_next == LOAD);
      resp_valid_q <= (state_next == RESP);
      if (accept) begin
        owner <= win_idx;
        mul_a <= bus.req_a[WORD_W*win_idx +: WORD_W];
        mul_b <= bus.req_b[WORD_W*win_idx +: WORD_W];
      end
      if (finish) begin
        resp_id_q   <= owner;
        resp_data_q <= abort ? '0 : mul_out;
      end
      if (state == RESP) ptr <= owner;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // The watchdog also resets the multiplier for one cycle so the next operation starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt    <= '0;
      abort_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 1'b1;
      abort_q <= abort;
      if (finish) resp_err_q <= abort;
    end
  end

  assign mul_reset    = reset | abort_q;
  assign bus.resp_err = resp_err_q;
`else
  assign mul_reset    = reset;
  assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a 33-cycle behavioural multiplier.
// Timeout expectations follow MULT_ARB_TIMEOUT_EN when it is defined.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int N   = 2;
  localparam int LAT = 33;
  localparam int TO  = 40;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        busy;
  logic        mul_start;
  logic        mul_reset;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_out   = '0;
  logic        mul_done  = 1'b0;

  mult_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_reset (mul_reset),
    .mul_out   (mul_out),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    bit          err;
    int          ready_cyc;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  logic [31:0] data_log[$];
  int          gap_log[$];
  exp_t        mon_e;
  int          mon_p;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_id = N - 1;
  int          start_count = 0;
  int          resp_count = 0;
  int          idle_cnt = 0;
  int          mcnt = 0;
  bit          started = 1'b0;
  bit          suppress_done = 1'b0;
  bit          last_err = 1'b0;
  int          last_resp_id = 0;
  int          grants_to[N];
  int          seen[N];
  logic [N-1:0] hold_on = '0;

  // Spec-level round-robin rule: first pending requester after the last one served.
  function automatic int modelPick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prodLow(logic [31:0] a, logic [31:0] b);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b};
    return full[31:0];
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterative multiplier: done rises LAT edges after it samples the start pulse.
  always @(posedge clk) begin
    if (mul_reset) begin
      mcnt     <= 0;
      mul_done <= 1'b0;
    end else if (mul_start) begin
      mcnt     <= LAT;
      mul_done <= 1'b0;
      mul_out  <= mul_a * mul_b;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !suppress_done) mul_done <= 1'b1;
    end
  end

  // Monitor and scoreboard: predicts grants, pushes expectations, pops on every response.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      exp_q.delete();
      last_id  = N - 1;
      started  = 1'b0;
      idle_cnt = 0;
    end else begin
      if (busy === 1'b1) begin
        if (idle_cnt > 0) gap_log.push_back(idle_cnt);
        idle_cnt = 0;
        checkOutput("ready_while_busy", bus.req_ready, '0);
      end else begin
        idle_cnt++;
        if (|bus.req_valid) begin
          mon_p = modelPick(bus.req_valid, last_id);
          checkOutput("grant", bus.req_ready, 1 << mon_p);
          mon_e.id        = mon_p;
          mon_e.a         = bus.req_a[32*mon_p +: 32];
          mon_e.b         = bus.req_b[32*mon_p +: 32];
          mon_e.err       = suppress_done && TO_EN;
          mon_e.data      = mon_e.err ? 32'd0 : prodLow(mon_e.a, mon_e.b);
          mon_e.ready_cyc = cyc;
          mon_e.due       = cyc + (mon_e.err ? TO + 2 : LAT + 3);
          exp_q.push_back(mon_e);
          grant_log.push_back(mon_p);
          grants_to[mon_p]++;
          last_id = mon_p;
          started = 1'b0;
        end
      end
      if (mul_start === 1'b1) begin
        start_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL start_without_grant actual=1 required=0");
        end else begin
          mon_e = exp_q[$];
          checkOutput("start_cycle", cyc, mon_e.ready_cyc + 1);
          checkOutput("mul_a", mul_a, mon_e.a);
          checkOutput("mul_b", mul_b, mon_e.b);
          checkOutput("start_once", started, 0);
          started = 1'b1;
        end
      end
      if (bus.resp_valid === 1'b1) begin
        resp_count++;
        data_log.push_back(bus.resp_data);
        last_err     = bus.resp_err;
        last_resp_id = int'(bus.resp_id);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp actual=1 required=0");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("resp_id", bus.resp_id, mon_e.id);
          checkOutput("resp_data", bus.resp_data, mon_e.data);
          checkOutput("resp_err", bus.resp_err, mon_e.err);
          checkOutput("resp_cycle", cyc, mon_e.due);
          checkOutput("mul_reset_at_resp", mul_reset, mon_e.err);
        end
      end
    end
  end

  task automatic setReq(int i, logic v, logic [31:0] a, logic [31:0] b);
    bus.req_valid[i]      = v;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  // One clock of stimulus: accepted requesters either drop or re-request with new operands.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (grants_to[i] != seen[i]) begin
        seen[i] = grants_to[i];
        if (hold_on[i]) begin
          bus.req_a[32*i +: 32] = $urandom;
          bus.req_b[32*i +: 32] = $urandom;
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic waitIdle(int lim);
    int t;
    for (t = 0; t < lim; t++) begin
      applyStimulus();
      if (exp_q.size() == 0 && busy === 1'b0 && bus.req_valid == '0) break;
    end
    if (t >= lim) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle_timeout actual=%0d required=<%0d", t, lim);
    end
  endtask

  task automatic resetDut(int n);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    hold_on       = '0;
    @(negedge clk);
    checkOutput("rst_mul_reset", mul_reset, 1);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) seen[i] = grants_to[i];
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_resp_id", bus.resp_id, 0);
    checkOutput("rst_resp_data", bus.resp_data, 0);
    checkOutput("rst_resp_err", bus.resp_err, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_mul_reset_released", mul_reset, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s, r, g, d, t, c1;
    for (int i = 0; i < N; i++) begin
      grants_to[i] = 0;
      seen[i]      = 0;
    end
    @(posedge clk);
    #1;
    resetDut(2);

    $display("[TB] single request");
    s = start_count;
    r = resp_count;
    setReq(0, 1'b1, 32'd7, 32'd6);
    waitIdle(200);
    checkOutput("t1_start_count", start_count - s, 1);
    checkOutput("t1_resp_count", resp_count - r, 1);
    checkOutput("t1_data", data_log[$], 42);
    checkOutput("t1_id", last_resp_id, 0);

    $display("[TB] contention");
    resetDut(1);
    g = grant_log.size();
    d = data_log.size();
    setReq(0, 1'b1, 32'd3, 32'd5);
    setReq(1, 1'b1, 32'h0000FFFF, 32'h00010001);
    waitIdle(300);
    checkOutput("t2_grants", grant_log.size() - g, 2);
    checkOutput("t2_first", grant_log[g], 0);
    checkOutput("t2_second", grant_log[g+1], 1);
    checkOutput("t2_data0", data_log[d], 15);
    checkOutput("t2_data1", data_log[d+1], 32'hFFFFFFFF);
    checkOutput("t2_idle_gap", gap_log[$], 1);

    $display("[TB] fairness");
    resetDut(1);
    g = grant_log.size();
    hold_on = '1;
    setReq(0, 1'b1, $urandom, $urandom);
    setReq(1, 1'b1, $urandom, $urandom);
    for (t = 0; t < 2000 && grant_log.size() - g < 6; t++) applyStimulus();
    bus.req_valid = '0;
    hold_on = '0;
    waitIdle(300);
    checkOutput("t3_grants", grant_log.size() - g, 6);
    for (int k = 0; k < 6; k++) checkOutput("t3_order", grant_log[g+k], k % 2);

    $display("[TB] reset mid-run");
    resetDut(1);
    s = start_count;
    setReq(0, 1'b1, $urandom, $urandom);
    for (t = 0; t < 50 && start_count == s; t++) applyStimulus();
    repeat (10) applyStimulus();
    checkOutput("t4_busy_before_reset", busy, 1);
    r = resp_count;
    resetDut(1);
    repeat (60) applyStimulus();
    checkOutput("t4_no_resp", resp_count - r, 0);
    setReq(1, 1'b1, $urandom, $urandom);
    waitIdle(200);
    checkOutput("t4_resp_after", resp_count - r, 1);
    checkOutput("t4_id", last_resp_id, 1);

    $display("[TB] withdraw");
    resetDut(1);
    g = grant_log.size();
    setReq(0, 1'b1, $urandom, $urandom);
    repeat (5) applyStimulus();
    checkOutput("t5_busy", busy, 1);
    setReq(1, 1'b1, $urandom, $urandom);
    applyStimulus();
    bus.req_valid[1] = 1'b0;
    waitIdle(200);
    c1 = 0;
    for (int k = g; k < grant_log.size(); k++) if (grant_log[k] == 1) c1++;
    checkOutput("t5_grants_to_1", c1, 0);
    checkOutput("t5_grants", grant_log.size() - g, 1);

    $display("[TB] stuck multiplier");
    resetDut(1);
    suppress_done = 1'b1;
    r = resp_count;
    setReq(0, 1'b1, $urandom, $urandom);
`ifdef MULT_ARB_TIMEOUT_EN
    waitIdle(200);
    checkOutput("t6_resp", resp_count - r, 1);
    checkOutput("t6_err", last_err, 1);
    checkOutput("t6_data", data_log[$], 0);
`else
    repeat (100) applyStimulus();
    checkOutput("t6_busy", busy, 1);
    checkOutput("t6_no_resp", resp_count - r, 0);
`endif
    suppress_done = 1'b0;
    resetDut(1);

    $display("[TB] random traffic");
    for (t = 0; t < 800; t++) begin
      applyStimulus();
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) setReq(i, 1'b1, $urandom, $urandom);
        end else if ($urandom_range(0, 31) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
        hold_on[i] = 1'($urandom_range(0, 1));
      end
    end
    bus.req_valid = '0;
    hold_on = '0;
    waitIdle(300);
    checkOutput("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
